vending_machine: RTL and testbench

- Newspaper vending controller; accepts 5- and 10-unit coins, one coin per clock.
- Dispenses a newspaper once accumulated credit reaches PRICE (default 15).
- Returns a 5-unit change flag when credit overshoots the price by 5.
- Sits between the coin-acceptor front end and the dispenser/change actuators; all outputs are registered.

---
 rtl/vending_machine.sv | 74 +++++++
 tb/tb_vending_machine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// Newspaper vending controller: accumulates 5/10 coins, vends at PRICE_UNITS steps, flags 5 change on overshoot.
// Outputs registered, 1-cycle latency; no backpressure. Optional SALES_COUNT_EN adds a wrapping vend counter.
module vending_machine #(
  parameter int PRICE_UNITS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       coin,
  output logic             newspaper,
  output logic             change_5
`ifdef SALES_COUNT_EN
  ,
  output logic [CNT_W-1:0] sales_count
`endif
);

  localparam int CW = $clog2(PRICE_UNITS + 2);
  localparam logic [CW-1:0] PRICE_V  = CW'(PRICE_UNITS);
  localparam logic [CW-1:0] PRICE_V1 = CW'(PRICE_UNITS + 1);

  logic [CW-1:0] r_credit;
  logic          r_newspaper;
  logic          r_change_5;
  logic [CW-1:0] w_add;
  logic [CW-1:0] w_sum;

  always_comb begin
    w_add = '0;
    case (coin)
      2'b01:   w_add = CW'(1);
      2'b10:   w_add = CW'(2);
      default: w_add = '0;
    endcase
    w_sum = r_credit + w_add;
  end

  // Outputs only change on a valid coin, so a vend stays latched through idle/invalid cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit    <= '0;
      r_newspaper <= 1'b0;
      r_change_5  <= 1'b0;
    end else if (w_add != '0) begin
      if (w_sum < PRICE_V) begin
        r_credit    <= w_sum;
        r_newspaper <= 1'b0;
        r_change_5  <= 1'b0;
      end else begin
        r_credit    <= '0;
        r_newspaper <= 1'b1;
        r_change_5  <= (w_sum == PRICE_V1);
      end
    end
  end

  assign newspaper = r_newspaper;
  assign change_5  = r_change_5;

`ifdef SALES_COUNT_EN
  logic [CNT_W-1:0] r_sales_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sales_count <= '0;
    end else if ((w_add != '0) && (w_sum >= PRICE_V)) begin
      r_sales_count <= r_sales_count + CNT_W'(1);
    end
  end

  assign sales_count = r_sales_count;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine (default PRICE_UNITS=3); checks outputs one cycle after each coin.
module tb_vending_machine;

  logic        clk;
  logic        reset;
  logic [1:0]  coin;
  logic        newspaper;
  logic        change_5;
`ifdef SALES_COUNT_EN
  logic [15:0] sales_count;
`endif

  int checks = 0;
  int errors = 0;

  vending_machine dut (
    .clk       (clk),
    .reset     (reset),
    .coin      (coin),
    .newspaper (newspaper),
    .change_5  (change_5)
`ifdef SALES_COUNT_EN
    ,
    .sales_count (sales_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a coin code for one cycle; returns 1 time unit after the sampling edge.
  task automatic put(input logic [1:0] c);
    coin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    coin  = 2'b00;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL reset_outputs: got %b want 00", {newspaper, change_5}); end
`ifdef SALES_COUNT_EN
    checks++; if (sales_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", sales_count); end
`endif
  endtask

  task automatic test_single_5();
    do_reset();
    put(2'b01); put(2'b00); put(2'b00);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL single5_idle: got %b want 00", {newspaper, change_5}); end
    // credit 1 + 2 = price exactly
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL single5_credit1: got %b want 10", {newspaper, change_5}); end
  endtask

  task automatic test_single_10();
    do_reset();
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL single10: got %b want 00", {newspaper, change_5}); end
    put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL single10_credit2: got %b want 10", {newspaper, change_5}); end
  endtask

  task automatic test_two_5();
    do_reset();
    put(2'b01); put(2'b00); put(2'b01); put(2'b00); put(2'b00);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL two5_idle: got %b want 00", {newspaper, change_5}); end
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b11) begin errors++; $display("FAIL two5_credit2: got %b want 11", {newspaper, change_5}); end
  endtask

  task automatic test_exact_vend();
    do_reset();
    put(2'b10); put(2'b00); put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL exact_vend: got %b want 10", {newspaper, change_5}); end
    put(2'b00); put(2'b00);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL exact_hold: got %b want 10", {newspaper, change_5}); end
`ifdef SALES_COUNT_EN
    checks++; if (sales_count !== 16'd1) begin errors++; $display("FAIL exact_count: got %0d want 1", sales_count); end
`endif
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL exact_clear: got %b want 00", {newspaper, change_5}); end
  endtask

  task automatic test_change();
    do_reset();
    put(2'b10); put(2'b00); put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b11) begin errors++; $display("FAIL change_vend: got %b want 11", {newspaper, change_5}); end
    put(2'b00); put(2'b11); put(2'b00);
    checks++; if ({newspaper, change_5} !== 2'b11) begin errors++; $display("FAIL change_hold: got %b want 11", {newspaper, change_5}); end
    put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL change_clear: got %b want 00", {newspaper, change_5}); end
    // new transaction started at credit 1
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL change_next: got %b want 10", {newspaper, change_5}); end
`ifdef SALES_COUNT_EN
    checks++; if (sales_count !== 16'd2) begin errors++; $display("FAIL change_count: got %0d want 2", sales_count); end
`endif
  endtask

  task automatic test_robust();
    do_reset();
    put(2'b01); put(2'b00); put(2'b01); put(2'b00); put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL three5_vend: got %b want 10", {newspaper, change_5}); end
    do_reset();
    put(2'b01); put(2'b11); put(2'b11);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL invalid_nocredit: got %b want 00", {newspaper, change_5}); end
    put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL invalid_credit2: got %b want 00", {newspaper, change_5}); end
    put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL invalid_vend: got %b want 10", {newspaper, change_5}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    put(2'b10); put(2'b10);
    coin = 2'b00;
    #2 reset = 1'b0;
    #1;
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL async_outputs: got %b want 00", {newspaper, change_5}); end
`ifdef SALES_COUNT_EN
    checks++; if (sales_count !== 16'd0) begin errors++; $display("FAIL async_count: got %0d want 0", sales_count); end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    put(2'b10);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    // credit must have been cleared from 2: a 5 coin now leaves credit at 1
    put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL async_credit_cleared: got %b want 00", {newspaper, change_5}); end
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL async_after: got %b want 10", {newspaper, change_5}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    put(2'b10); put(2'b01);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL b2b_first: got %b want 10", {newspaper, change_5}); end
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b00) begin errors++; $display("FAIL b2b_clear: got %b want 00", {newspaper, change_5}); end
    put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b11) begin errors++; $display("FAIL b2b_second: got %b want 11", {newspaper, change_5}); end
    put(2'b01); put(2'b10);
    checks++; if ({newspaper, change_5} !== 2'b10) begin errors++; $display("FAIL b2b_third: got %b want 10", {newspaper, change_5}); end
`ifdef SALES_COUNT_EN
    checks++; if (sales_count !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", sales_count); end
`endif
  endtask

  initial begin
    reset = 1'b0;
    coin  = 2'b00;
    #12;
    test_reset();
    test_single_5();
    test_single_10();
    test_two_5();
    test_exact_vend();
    test_change();
    test_robust();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
